// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, opcode classes, FSM encoding
// and the EX/MEM payload bundle.
package cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_EVU = 4'd2;
  localparam logic [3:0] OP_EVL = 4'd3;
  localparam logic [3:0] OP_GTE = 4'd4;
  localparam logic [3:0] OP_LTZ = 4'd5;
  localparam logic [3:0] OP_EZ  = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_NE  = 4'd8;

  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_SQUASH = 1'b1;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] result;
    logic [3:0]  rd;
  } ex_mem_t;

  function automatic logic is_branch(input logic [3:0] op);
    return (op >= OP_GTE) && (op <= OP_NE);
  endfunction

  function automatic logic is_wb(input logic [3:0] op);
    return op <= OP_EVL;
  endfunction

endpackage

// File: rtl/branch_target.sv
// Branch target adder: pc + 1 + imm, wrapping modulo 2^16.
// Shared with the fetch stage.
module branch_target (
  input  logic [15:0] i_pc,
  input  logic [15:0] i_imm,
  output logic [15:0] o_target
);

  assign o_target = i_pc + 16'd1 + i_imm;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, PC redirect
// and squash of younger in-flight instructions.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int NOP_SQUASH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  in_op,
  input  logic [15:0] in_result,
  input  logic        in_taken,
  input  logic [15:0] in_pc,
  input  logic [15:0] in_imm,
  input  logic [3:0]  in_rd,
  input  logic        mem_ready,
  output logic        in_ready,
  output logic        stall,
  output logic        out_valid,
  output logic [3:0]  out_op,
  output logic [15:0] out_result,
  output logic [3:0]  out_rd,
  output logic        out_wb_en,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        flush
);

  logic        r_state;
  logic [1:0]  r_sq_cnt;
  logic        r_valid;
  ex_mem_t     r_q;
  logic        r_redir;
  logic [15:0] r_redir_pc;

  logic        w_stall;
  logic        w_acc;
  logic        w_acc_run;
  logic        w_acc_sq;
  logic        w_drain;
  logic        w_taken;
  logic [15:0] w_target;

  branch_target u_target (
    .i_pc     (in_pc),
    .i_imm    (in_imm),
    .o_target (w_target)
  );

  assign w_stall   = r_valid && !mem_ready;
  assign w_acc     = in_valid && !w_stall;
  assign w_acc_run = w_acc && (r_state == ST_RUN);
  assign w_acc_sq  = w_acc && (r_state == ST_SQUASH);
  assign w_drain   = !w_acc && mem_ready;
  // Stale ALU flag is only meaningful on branch opcodes
  assign w_taken   = is_branch(in_op) && in_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_sq_cnt   <= 2'd0;
      r_valid    <= 1'b0;
      r_q        <= '0;
      r_redir    <= 1'b0;
      r_redir_pc <= 16'd0;
    end else begin
      r_redir <= 1'b0;
      unique case (1'b1)
        w_acc_sq: begin
          r_valid  <= 1'b0;
          r_sq_cnt <= r_sq_cnt - 2'd1;
          if (r_sq_cnt == 2'd1)
            r_state <= ST_RUN;
        end
        w_acc_run: begin
          r_valid     <= 1'b1;
          r_q.op      <= in_op;
          r_q.result  <= in_result;
          r_q.rd      <= in_rd;
          if (w_taken) begin
            r_redir    <= 1'b1;
            r_redir_pc <= w_target;
            r_state    <= ST_SQUASH;
            r_sq_cnt   <= 2'(NOP_SQUASH);
          end
        end
        w_drain: r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign stall          = w_stall;
  assign in_ready       = !w_stall;
  assign out_valid      = r_valid;
  assign out_op         = r_q.op;
  assign out_result     = r_q.result;
  assign out_rd         = r_q.rd;
  assign out_wb_en      = r_valid && is_wb(r_q.op);
  assign redirect_valid = r_redir;
  assign redirect_pc    = r_redir_pc;
  assign flush          = (r_state == ST_SQUASH);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed plus randomized checks of ex_mem_stage against a
// transaction-level reference model.
module tb_ex_mem_stage;

  localparam int NSQ = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [15:0] in_result;
  logic        in_taken;
  logic [15:0] in_pc;
  logic [15:0] in_imm;
  logic [3:0]  in_rd;
  logic        mem_ready;
  logic        in_ready;
  logic        stall;
  logic        out_valid;
  logic [3:0]  out_op;
  logic [15:0] out_result;
  logic [3:0]  out_rd;
  logic        out_wb_en;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        flush;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic        m_valid;
  int          m_op;
  int          m_res;
  int          m_rd;
  logic        m_rv;
  int          m_rpc;
  int          m_left;

  ex_mem_stage #(.NOP_SQUASH(NSQ)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_op          (in_op),
    .in_result      (in_result),
    .in_taken       (in_taken),
    .in_pc          (in_pc),
    .in_imm         (in_imm),
    .in_rd          (in_rd),
    .mem_ready      (mem_ready),
    .in_ready       (in_ready),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_op         (out_op),
    .out_result     (out_result),
    .out_rd         (out_rd),
    .out_wb_en      (out_wb_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_op    = 0;
    m_res   = 0;
    m_rd    = 0;
    m_rv    = 1'b0;
    m_rpc   = 0;
    m_left  = 0;
  endtask

  task automatic chk_outputs();
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("out_op", int'(out_op), m_op);
    chk("out_result", int'(out_result), m_res);
    chk("out_rd", int'(out_rd), m_rd);
    chk("out_wb_en", int'(out_wb_en),
        int'(m_valid && m_op <= 3));
    chk("redirect_valid", int'(redirect_valid), int'(m_rv));
    chk("redirect_pc", int'(redirect_pc), m_rpc);
    chk("flush", int'(flush), int'(m_left > 0));
  endtask

  // called just after a falling edge; returns just after the next one
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk_outputs();
    chk("rst_stall", int'(stall), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic v, input int op, input int res,
                      input logic tk, input int pc, input int imm,
                      input int rd, input logic mr);
    logic e_stall;
    logic acc;
    in_valid  = v;
    in_op     = 4'(op);
    in_result = 16'(res);
    in_taken  = tk;
    in_pc     = 16'(pc);
    in_imm    = 16'(imm);
    in_rd     = 4'(rd);
    mem_ready = mr;
    #1;
    e_stall = m_valid && !mr;
    chk("stall", int'(stall), int'(e_stall));
    chk("in_ready", int'(in_ready), int'(!e_stall));
    acc  = v && !e_stall;
    m_rv = 1'b0;
    if (acc && m_left > 0) begin
      m_left--;
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_op    = op;
      m_res   = res;
      m_rd    = rd;
      if (op >= 4 && op <= 8 && tk) begin
        m_rv   = 1'b1;
        m_rpc  = (pc + 1 + imm) % 65536;
        m_left = NSQ;
      end
    end else if (mr) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk_outputs();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_result = '0; in_taken = 1'b0;
    in_pc = '0; in_imm = '0; in_rd = '0; mem_ready = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // add after reset, stale taken flag ignored
    step(1, 0, 16'h0005, 1, 16'h0100, 16'h0003, 3, 1);
    chk("add_res", int'(out_result), 16'h0005);
    chk("add_wb", int'(out_wb_en), 1);
    chk("add_noredir", int'(redirect_valid), 0);

    // taken eq with negative offset, then two squashed, one kept
    step(1, 7, 16'h0001, 1, 16'h0010, 16'hFFFC, 1, 1);
    chk("eq_rv", int'(redirect_valid), 1);
    chk("eq_rpc", int'(redirect_pc), 16'h000D);
    chk("eq_wb", int'(out_wb_en), 0);
    chk("eq_flush", int'(flush), 1);
    step(1, 0, 16'h1111, 0, 16'h0011, 0, 2, 1);
    chk("sq1_rv", int'(redirect_valid), 0);
    chk("sq1_valid", int'(out_valid), 0);
    step(1, 1, 16'h2222, 0, 16'h0012, 0, 2, 1);
    chk("sq2_flush", int'(flush), 0);
    step(1, 1, 16'h3333, 0, 16'h000D, 0, 4, 1);
    chk("post_sq_res", int'(out_result), 16'h3333);

    // wrapping target, squash held over idle cycles
    step(1, 8, 16'h0000, 1, 16'hFFFF, 16'h0002, 0, 1);
    chk("ne_rpc", int'(redirect_pc), 16'h0002);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("hold_flush", int'(flush), 1);
    step(1, 2, 16'h0AAA, 0, 16'h0002, 0, 5, 1);
    step(1, 3, 16'h0BBB, 0, 16'h0003, 0, 6, 1);
    chk("hold_done", int'(flush), 0);

    // taken gte while stalled, then released
    step(1, 0, 16'h0042, 0, 16'h0020, 0, 7, 1);
    step(1, 4, 16'h0001, 1, 16'h0021, 16'h0010, 8, 0);
    chk("stl_rv", int'(redirect_valid), 0);
    chk("stl_res", int'(out_result), 16'h0042);
    step(1, 4, 16'h0001, 1, 16'h0021, 16'h0010, 8, 1);
    chk("gte_rv", int'(redirect_valid), 1);
    chk("gte_rpc", int'(redirect_pc), 16'h0032);

    // second taken branch inside squash window is dropped
    step(1, 6, 16'h0001, 1, 16'h0022, 16'h0100, 9, 1);
    chk("br_sq_rv", int'(redirect_valid), 0);
    chk("br_sq_flush", int'(flush), 1);
    step(1, 0, 16'h0007, 0, 16'h0023, 0, 1, 1);
    chk("br_sq_end", int'(flush), 0);

    // reset while squashing
    step(1, 5, 16'h0001, 1, 16'h0040, 16'h0004, 1, 1);
    do_reset();
    step(1, 0, 16'h0099, 0, 16'h0050, 0, 2, 1);
    chk("rst_add_wb", int'(out_wb_en), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        int op;
        op = ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, 8))
                                         : int'($urandom_range(0, 15));
        step(($urandom_range(0, 4) != 0), op, int'($urandom_range(0, 65535)),
             logic'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 15)),
             ($urandom_range(0, 3) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline register with branch resolution, sitting directly downstream of the execute ALU. It captures the ALU result and branch flag for each instruction and forwards them to the memory/writeback side. On a taken branch (ops 4–8) it issues a one-cycle PC redirect and squashes the two younger instructions already in flight. It absorbs memory back-pressure by holding its register and stalling upstream.

## Interface
Parameters:
- `NOP_SQUASH`, default 2: number of younger instructions dropped after a taken branch (1..3).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  execute stage presents an instruction this cycle.
- `in_op`  in  4  ALU opcode: 0 add, 1 sub, 2 evenUpper, 3 evenLower, 4 gte, 5 ltz, 6 ez, 7 eq, 8 ne, 9–15 nop.
- `in_result`  in  16  ALU result.
- `in_taken`  in  1  ALU branch condition.
- `in_pc`  in  16  word address of the instruction.
- `in_imm`  in  16  signed branch offset, in words.
- `in_rd`  in  4  destination register.
- `mem_ready`  in  1  downstream accepts `out_*` this cycle.
- `in_ready`  out  1  stage accepts the input this cycle; equals `!stall`.
- `stall`  out  1  combinational: `out_valid && !mem_ready`.
- `out_valid`  out  1  registered instruction is valid.
- `out_op`  out  4  registered opcode.
- `out_result`  out  16  registered result.
- `out_rd`  out  4  registered destination register.
- `out_wb_en`  out  1  `out_valid` and opcode is 0–3.
- `redirect_valid`  out  1  single-cycle pulse: fetch must load `redirect_pc`.
- `redirect_pc`  out  16  branch target.
- `flush`  out  1  high while in the SQUASH state; upstream stages invalidate younger instructions.

## Operation
- **Accept:** the input is accepted when `in_valid && in_ready`. The register loads on acceptance. If `mem_ready` is high and nothing is accepted, `out_valid` goes to 0.
- **Branch flag sampling:** `in_taken` is sampled only for ops 4–8. The ALU holds a stale flag on other ops, so the flag is ignored for ops 0–3 and 9–15.
- **Taken branch:** an accepted instruction with op 4–8 and `in_taken=1`, in RUN state, is a taken branch.
  - `redirect_pc` = `in_pc + 1 + in_imm`, computed modulo 2^16 with wrap-around and no overflow flag.
  - The branch itself is registered with `out_wb_en=0`.
- **Not-taken branch:** registered with `out_wb_en=0`; no redirect.
- **Nop ops (9–15):** registered with `out_valid=1` and `out_wb_en=0`.
- **FSM states:**
  - RUN: normal flow; a taken branch moves to SQUASH with `sq_cnt=NOP_SQUASH`.
  - SQUASH: each accepted input is dropped (nothing loads, `out_valid` is cleared when `mem_ready` is high) and `sq_cnt` decrements. At `sq_cnt` reaching 0, return to RUN.
  - SQUASH with no acceptance (`in_valid=0` or stalled): hold state and count.
- **Simultaneous events:**
  - Taken branch while stalled: not accepted, no redirect until it is accepted.
  - Branch arriving in SQUASH: dropped, no redirect.
- **Reset mid-operation:** the FSM returns to RUN and a pending squash count is discarded.

## Timing
- Latency: 1 cycle from acceptance to `out_*`.
- `redirect_valid` asserts in the cycle after the taken branch is accepted, for exactly 1 cycle. `flush` rises in that same cycle.
- `stall` and `in_ready` are combinational from `out_valid` and `mem_ready` (zero-cycle).
- While stalled, all `out_*` outputs hold stable.
- Reset values: `out_valid=0`, `out_op=0`, `out_result=0`, `out_rd=0`, `out_wb_en=0`, `redirect_valid=0`, `redirect_pc=0`, `flush=0`, state RUN, `sq_cnt=0`.

## Structure
- The shared package `cpu_pkg` holds:
  - the opcode localparams (`OP_ADD`..`OP_NE`),
  - the `is_branch(op)` and `is_wb(op)` functions,
  - the FSM state encoding (RUN=0, SQUASH=1).
- The ALU imports the same opcode constants.
- One sub-module, `branch_target`: a combinational 16-bit `pc + 1 + imm` adder, reused later by fetch.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream → all outputs 0 and state RUN; the first accepted add after release appears 1 cycle later with `out_wb_en=1`.
- **Stale flag:** add (op 0, result 0x0005, `in_taken=1`) → `out_result=0x0005`, `out_wb_en=1`, no redirect.
- **Taken branch with squash:** eq (op 7) taken at `in_pc=0x0010`, `in_imm=0xFFFC` → `redirect_pc=0x000D`, `redirect_valid` for 1 cycle. The next 2 accepted instructions are dropped and the 3rd is registered.
- **Wrap and squash hold:** ne taken at `in_pc=0xFFFF`, `in_imm=0x0002` → `redirect_pc=0x0002`. With `in_valid=0` during SQUASH, `flush` holds until 2 inputs are accepted.
- **Stall on a branch:** `mem_ready=0` with a valid output and a taken gte arriving → `stall=1`, outputs stable, no redirect. `mem_ready=1` → the gte is accepted and `redirect_valid` pulses the next cycle.
- **Branch during squash:** second taken branch arriving in SQUASH → dropped, `redirect_valid` stays 0, squash count continues.
